// File: rtl/ram_access_ctrl.sv
// Request/response front end for the 32x16 synchronous RAM, absorbing its one-cycle registered read.
// Optional write read-back verify is enabled by defining RAM_ACCESS_CTRL_WRITE_VERIFY_EN.
module ram_access_ctrl #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  busy,
  output logic                  ram_write_enable,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never depends on ready, and the response is held unchanged until it transfers.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT      = 3'd2,
`ifdef RAM_ACCESS_CTRL_WRITE_VERIFY_EN
    S_VRD_ISSUE = 3'd3,
    S_VRD_WAIT  = 3'd4,
`endif
    S_RESP      = 3'd5
  } state_e;

  state_e                state_q, state_d;
  logic                  write_q, write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
`ifdef RAM_ACCESS_CTRL_WRITE_VERIFY_EN
  logic                  rsp_error_q, rsp_error_d;
`endif

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rsp_rdata_q;
`ifdef RAM_ACCESS_CTRL_WRITE_VERIFY_EN
    rsp_error_d = rsp_error_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (write_q) begin
`ifdef RAM_ACCESS_CTRL_WRITE_VERIFY_EN
          state_d     = S_VRD_ISSUE;
`else
          rsp_rdata_d = wdata_q;
          state_d     = S_RESP;
`endif
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // RAM output now reflects the address presented during ISSUE.
        rsp_rdata_d = ram_data_out;
`ifdef RAM_ACCESS_CTRL_WRITE_VERIFY_EN
        rsp_error_d = 1'b0;
`endif
        state_d     = S_RESP;
      end
`ifdef RAM_ACCESS_CTRL_WRITE_VERIFY_EN
      S_VRD_ISSUE: state_d = S_VRD_WAIT;
      S_VRD_WAIT: begin
        rsp_rdata_d = ram_data_out;
        rsp_error_d = (ram_data_out != wdata_q);
        state_d     = S_RESP;
      end
`endif
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_rdata_q <= '0;
`ifdef RAM_ACCESS_CTRL_WRITE_VERIFY_EN
      rsp_error_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef RAM_ACCESS_CTRL_WRITE_VERIFY_EN
      rsp_error_q <= rsp_error_d;
`endif
    end
  end

  // Reset gates the write strobe so an aborted write never reaches the RAM.
  assign req_ready        = (state_q == S_IDLE) && !reset;
  assign rsp_valid        = (state_q == S_RESP);
  assign busy             = (state_q != S_IDLE);
  assign ram_write_enable = (state_q == S_ISSUE) && write_q && !reset;
  assign ram_address      = addr_q;
  assign ram_data_in      = wdata_q;
  assign rsp_rdata        = rsp_rdata_q;
`ifdef RAM_ACCESS_CTRL_WRITE_VERIFY_EN
  assign rsp_error        = rsp_error_q;
`else
  assign rsp_error        = 1'b0;
`endif

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Bench for ram_access_ctrl: behavioural 32x16 RAM, reference memory array and expected-data queue.
module tb_ram_access_ctrl;

`ifdef RAM_ACCESS_CTRL_WRITE_VERIFY_EN
  localparam int WR_LAT = 4;
`else
  localparam int WR_LAT = 2;
`endif
  localparam int RD_LAT = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [4:0]  req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_rdata;
  logic        rsp_error;
  logic        busy;
  logic        ram_write_enable;
  logic [4:0]  ram_address;
  logic [15:0] ram_data_in;
  logic [15:0] ram_data_out;

  int n_cmp = 0;
  int n_fail = 0;
  logic [15:0] ref_mem [32];
  logic [15:0] exp_q [$];

  // ---- clock / reset ----
  always #5 clock = ~clock;

  // ---- RAM device model: synchronous write, registered read, cleared by reset ----
  logic [15:0] ram_mem [32];
  logic [15:0] ram_dout;
  logic        corrupt = 1'b0;
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) ram_mem[i] <= '0;
      ram_dout <= '0;
    end else begin
      if (ram_write_enable) ram_mem[ram_address] <= ram_data_in;
      ram_dout <= ram_mem[ram_address];
    end
  end
  assign ram_data_out = corrupt ? 16'h1234 : ram_dout;

  ram_access_ctrl #(.ADDR_WIDTH(5), .DATA_WIDTH(16)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .busy(busy),
    .ram_write_enable(ram_write_enable), .ram_address(ram_address),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---- driver: one transaction, reports observations; scenarios do the comparing ----
  task automatic run_txn(input bit wr, input logic [4:0] a, input logic [15:0] d, input int hold,
                         output int lat, output logic [15:0] rdata, output logic err,
                         output int we_cnt, output logic [4:0] we_addr, output logic [15:0] we_data,
                         output bit stable, output bit ok);
    int guard;
    lat = 0; we_cnt = 0; we_addr = '0; we_data = '0; stable = 1'b1; ok = 1'b0;
    rdata = '0; err = 1'b0;
    @(negedge clock);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    if (!req_ready) begin
      req_valid = 1'b0;
      return;
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clock);
      lat++;
      if (lat == 1) begin
        #1;
        req_valid = 1'b0;
        req_write = 1'($urandom_range(1, 0));
        req_addr  = 5'($urandom);
        req_wdata = 16'($urandom);
      end
      @(negedge clock);
      if (ram_write_enable) begin
        we_cnt++;
        we_addr = ram_address;
        we_data = ram_data_in;
      end
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) return;
    rdata = rsp_rdata;
    err   = rsp_error;
    repeat (hold) begin
      @(negedge clock);
      if (!(rsp_valid === 1'b1 && rsp_rdata === rdata && rsp_error === err &&
            req_ready === 1'b0 && ram_write_enable === 1'b0)) stable = 1'b0;
    end
    rsp_ready = 1'b1;
    @(posedge clock);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b1; req_write = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    n_cmp++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0 || ram_write_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: req_ready=%b rsp_valid=%b busy=%b we=%b, required 0 0 0 0",
               req_ready, rsp_valid, busy, ram_write_enable);
    end
    n_cmp++;
    if (rsp_rdata !== 16'h0 || rsp_error !== 1'b0 || ram_address !== 5'h0 || ram_data_in !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_regs: rdata=%h err=%b addr=%h din=%h, required all 0",
               rsp_rdata, rsp_error, ram_address, ram_data_in);
    end
    @(posedge clock);
    #1 reset = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    for (int i = 0; i < 32; i++) ref_mem[i] = '0;
    @(negedge clock);
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b required 1", req_ready);
    end
  endtask

  task automatic test_directed();
    bit wr_l [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [4:0] a_l [6] = '{5'd5, 5'd5, 5'd6, 5'd31, 5'd0, 5'd31};
    logic [15:0] d_l [6] = '{16'hA5A5, 16'h0, 16'h0, 16'hFFFF, 16'h0001, 16'h0};
    int lat, we_cnt; logic [15:0] rdata, we_data, exp; logic err; logic [4:0] we_addr; bit stable, ok;
    for (int k = 0; k < 7; k++) begin
      bit wr; logic [4:0] a; logic [15:0] d;
      if (k < 6) begin wr = wr_l[k]; a = a_l[k]; d = d_l[k]; end
      else begin wr = 1'b0; a = 5'd0; d = 16'h0; end
      exp = wr ? d : ref_mem[a];
      if (wr) ref_mem[a] = d;
      run_txn(wr, a, d, 0, lat, rdata, err, we_cnt, we_addr, we_data, stable, ok);
      n_cmp++;
      if (!ok || lat !== (wr ? WR_LAT : RD_LAT)) begin
        n_fail++;
        $display("FAIL dir_latency[%0d]: ok=%b lat=%0d required %0d", k, ok, lat, wr ? WR_LAT : RD_LAT);
      end
      n_cmp++;
      if (rdata !== exp || err !== 1'b0) begin
        n_fail++;
        $display("FAIL dir_rdata[%0d]: got %h err=%b required %h err=0", k, rdata, err, exp);
      end
      n_cmp++;
      if (we_cnt !== (wr ? 1 : 0) || (wr && (we_addr !== a || we_data !== d))) begin
        n_fail++;
        $display("FAIL dir_ram_write[%0d]: cnt=%0d addr=%h data=%h required cnt=%0d addr=%h data=%h",
                 k, we_cnt, we_addr, we_data, wr ? 1 : 0, a, d);
      end
    end
  endtask

  task automatic test_random();
    int lat, we_cnt; logic [15:0] rdata, we_data, exp; logic err; logic [4:0] we_addr; bit stable, ok;
    for (int k = 0; k < 40; k++) begin
      bit wr = 1'($urandom_range(1, 0));
      logic [4:0] a = 5'($urandom);
      logic [15:0] d = 16'($urandom);
      int hold = $urandom_range(3, 0);
      exp_q.push_back(wr ? d : ref_mem[a]);
      if (wr) ref_mem[a] = d;
      run_txn(wr, a, d, hold, lat, rdata, err, we_cnt, we_addr, we_data, stable, ok);
      exp = exp_q.pop_front();
      n_cmp++;
      if (!ok || lat !== (wr ? WR_LAT : RD_LAT)) begin
        n_fail++;
        $display("FAIL rnd_latency[%0d]: ok=%b lat=%0d required %0d", k, ok, lat, wr ? WR_LAT : RD_LAT);
      end
      n_cmp++;
      if (rdata !== exp || err !== 1'b0) begin
        n_fail++;
        $display("FAIL rnd_rdata[%0d]: got %h err=%b required %h err=0", k, rdata, err, exp);
      end
      n_cmp++;
      if (we_cnt !== (wr ? 1 : 0) || (wr && (we_addr !== a || we_data !== d))) begin
        n_fail++;
        $display("FAIL rnd_ram_write[%0d]: cnt=%0d addr=%h data=%h required cnt=%0d addr=%h data=%h",
                 k, we_cnt, we_addr, we_data, wr ? 1 : 0, a, d);
      end
      n_cmp++;
      if (stable !== 1'b1) begin
        n_fail++;
        $display("FAIL rnd_hold_stable[%0d]: got %b required 1 (hold=%0d)", k, stable, hold);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat, we_cnt, guard; logic [15:0] rdata, we_data; logic err; logic [4:0] we_addr; bit stable, ok;
    logic [4:0] a = 5'd12;
    logic [4:0] b = 5'd15;
    logic [15:0] d1 = 16'($urandom);
    logic [15:0] d2 = 16'($urandom);
    bit we_seen = 1'b0;
    ref_mem[a] = d1;
    run_txn(1'b1, a, d1, 0, lat, rdata, err, we_cnt, we_addr, we_data, stable, ok);
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b0; req_addr = a;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_idle_ready: got %b required 1", req_ready);
    end
    @(posedge clock);
    #1 req_write = 1'b1; req_addr = b; req_wdata = d2;
    guard = 0;
    do begin
      @(negedge clock);
      if (ram_write_enable) we_seen = 1'b1;
      guard++;
    end while (!rsp_valid && guard < 20);
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      if (ram_write_enable) we_seen = 1'b1;
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== d1 || req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: valid=%b rdata=%h ready=%b required 1 %h 0",
                 c, rsp_valid, rsp_rdata, req_ready, d1);
      end
    end
    n_cmp++;
    if (we_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_no_early_accept: write strobe seen=%b required 0", we_seen);
    end
    rsp_ready = 1'b1;
    @(posedge clock);
    #1 rsp_ready = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_after_handshake: ready=%b busy=%b valid=%b required 1 0 0", req_ready, busy, rsp_valid);
    end
    @(posedge clock);
    #1 req_valid = 1'b0;
    ref_mem[b] = d2;
    @(negedge clock);
    n_cmp++;
    if (ram_write_enable !== 1'b1 || ram_address !== b || ram_data_in !== d2) begin
      n_fail++;
      $display("FAIL bp_second_write: we=%b addr=%h din=%h required 1 %h %h",
               ram_write_enable, ram_address, ram_data_in, b, d2);
    end
    guard = 0;
    while (!rsp_valid && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    rsp_ready = 1'b1;
    @(posedge clock);
    #1 rsp_ready = 1'b0;
    run_txn(1'b0, b, 16'h0, 0, lat, rdata, err, we_cnt, we_addr, we_data, stable, ok);
    n_cmp++;
    if (!ok || rdata !== ref_mem[b]) begin
      n_fail++;
      $display("FAIL bp_readback: ok=%b got %h required %h", ok, rdata, ref_mem[b]);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat, we_cnt; logic [15:0] rdata, we_data; logic err; logic [4:0] we_addr; bit stable, ok;
    bit rsp_seen = 1'b0;
    // abort a read during WAIT
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 5'd5;
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    for (int i = 0; i < 32; i++) ref_mem[i] = '0;
    @(negedge clock);
    n_cmp++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_wait_idle: valid=%b busy=%b ready=%b required 0 0 1", rsp_valid, busy, req_ready);
    end
    repeat (4) begin
      @(negedge clock);
      if (rsp_valid) rsp_seen = 1'b1;
    end
    n_cmp++;
    if (rsp_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_no_response: response seen=%b required 0", rsp_seen);
    end
    // abort a write in ISSUE: no strobe while reset is high
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 5'd9; req_wdata = 16'hBEEF;
    @(posedge clock);
    #1 req_valid = 1'b0; reset = 1'b1;
    @(negedge clock);
    n_cmp++;
    if (ram_write_enable !== 1'b0 || req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_issue_no_write: we=%b ready=%b required 0 0", ram_write_enable, req_ready);
    end
    @(posedge clock);
    #1 reset = 1'b0;
    run_txn(1'b0, 5'd5, 16'h0, 0, lat, rdata, err, we_cnt, we_addr, we_data, stable, ok);
    n_cmp++;
    if (!ok || rdata !== ref_mem[5] || lat !== RD_LAT) begin
      n_fail++;
      $display("FAIL rst_fresh_read: ok=%b got %h lat=%0d required %h lat=%0d", ok, rdata, lat, ref_mem[5], RD_LAT);
    end
  endtask

`ifdef RAM_ACCESS_CTRL_WRITE_VERIFY_EN
  task automatic test_verify_error();
    int lat, we_cnt; logic [15:0] rdata, we_data; logic err; logic [4:0] we_addr; bit stable, ok;
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 5'd20; req_wdata = 16'h4321;
    ref_mem[20] = 16'h4321;
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(posedge clock);
    #1 corrupt = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1 corrupt = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_error !== 1'b1 || rsp_rdata !== 16'h1234) begin
      n_fail++;
      $display("FAIL verify_error: valid=%b err=%b rdata=%h required 1 1 1234", rsp_valid, rsp_error, rsp_rdata);
    end
    rsp_ready = 1'b1;
    @(posedge clock);
    #1 rsp_ready = 1'b0;
    run_txn(1'b0, 5'd20, 16'h0, 0, lat, rdata, err, we_cnt, we_addr, we_data, stable, ok);
    n_cmp++;
    if (!ok || rdata !== ref_mem[20] || err !== 1'b0) begin
      n_fail++;
      $display("FAIL verify_readback: got %h err=%b required %h err=0", rdata, err, ref_mem[20]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_op();
`ifdef RAM_ACCESS_CTRL_WRITE_VERIFY_EN
    test_verify_error();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
